lieat_ifu_ifetch_req: RTL and testbench
=======================================

# lieat_ifu_ifetch_req

Fetch-request side of the IFU. It owns the architectural fetch PC and issues one instruction-memory request at a time through a valid/ready handshake. It computes the next PC from the decode and prediction results returned by the fetch-response stage: sequential, JAL, JALR, or a predicted-taken branch. It also handles EXU redirects, JALR operand stalls and FENCE.I drains.

## Interface
Parameters
- RESET_PC, 32'h8000_0000, first fetch address after reset
- XLEN, 32, address/data width (matches `XLEN)
- BPU_IDX, 6, BPU index width (matches `BPU_IDX)

Ports
- clock  in  1  single clock
- reset  in  1  asynchronous, active-low reset
- req_o_valid  out  1  fetch request valid
- req_i_ready  in  1  memory accepts request
- req_o_addr  out  XLEN  fetch address, word aligned
- req_o_index  out  BPU_IDX  BPU index, = req_o_addr[BPU_IDX+1:2]
- rsp_i_valid  in  1  memory returns instruction this cycle
- rsp_i_jal  in  1  decoded jal/jalr
- rsp_i_rs1en  in  1  with jal, marks jalr
- rsp_i_bxx  in  1  decoded conditional branch
- rsp_i_immb  in  XLEN  decoded jump/branch immediate
- rsp_i_prdt_taken  in  1  BPU prediction for the returned branch
- rsp_i_fencei  in  1  decoded FENCE.I
- jalr_i_rs1_val  in  XLEN  rs1 value from regfile/bypass
- jalr_i_rs1_rdy  in  1  rs1 value valid (no pending writer)
- flush_i_valid  in  1  EXU redirect
- flush_i_pc  in  XLEN  redirect target
- fencei_i_done  in  1  backend drained; FENCE.I complete
- ifu_o_pc  out  XLEN  PC of the instruction on rsp_i_valid
- ifu_o_drop  out  1  returned instruction is stale; downstream discards it

## Operation
- States: REQ, WAIT_RSP, WAIT_JALR, WAIT_FENCEI. Reset state is REQ with pc = RESET_PC.
- REQ: req_o_valid=1, req_o_addr=pc. On req_i_ready, latch ifu_o_pc=pc and go to WAIT_RSP.
- WAIT_RSP: wait for rsp_i_valid. At most one request is outstanding. On response:
  - jal & !rs1en -> pc = ifu_o_pc + immb
  - jal & rs1en -> if jalr_i_rs1_rdy, pc = (rs1_val + immb) & ~3; otherwise latch immb and go to WAIT_JALR
  - bxx & prdt_taken -> pc = ifu_o_pc + immb
  - fencei -> pc = ifu_o_pc + 4 and go to WAIT_FENCEI
  - otherwise -> pc = ifu_o_pc + 4
  - Every case except WAIT_JALR/WAIT_FENCEI returns to REQ.
- WAIT_JALR: when jalr_i_rs1_rdy, pc = (rs1_val + latched imm) & ~3 and go to REQ.
- WAIT_FENCEI: when fencei_i_done, go to REQ.
- All address arithmetic is modulo 2^XLEN; overflow wraps silently.
- Flush:
  - Overrides every state and every same-cycle event. pc = flush_i_pc.
  - If a request is outstanding (WAIT_RSP, or REQ accepted in the same cycle), set drop_pending. The next rsp_i_valid is then flagged ifu_o_drop=1, ignored for PC update, and clears drop_pending.
  - Flush in WAIT_RSP: wait for the stale response (with drop) before re-entering REQ.
  - Flush in any other state: go directly to REQ.
- ifu_o_drop = rsp_i_valid & (drop_pending | flush_i_valid).
- Reset mid-transaction: all state returns to its reset value immediately. Any response arriving after reset without a matching request is ignored.

## Timing
- Reset values: req_o_valid=1, req_o_addr=RESET_PC, req_o_index=RESET_PC[BPU_IDX+1:2], ifu_o_pc=RESET_PC, ifu_o_drop=0, drop_pending=0.
- req_o_addr and req_o_valid are registered. Both are held stable while req_o_valid & !req_i_ready.
- Next request is presented the cycle after the response (or after jalr_rdy / fencei_done / flush). Peak throughput with a 1-cycle memory is one instruction per 2 cycles.
- rsp_i_* decode and prediction inputs are combinational from the response stage and sampled only when rsp_i_valid.

## Structure
- lieat_ifu_ifetch_req_pkg (or the shared define file) holds the state encoding (2 bits) and RESET_PC default. XLEN and BPU_IDX come from the existing global defines.
- One natural sub-module: lieat_ifu_nextpc, the combinational next-PC mux/adder.
- Flops use lieat_general_dfflr-style cells with async active-low clear.

## Test plan
- Reset release, req_i_ready=1, memory returns nop (no jal/bxx) -> requests at 0x8000_0000, 0x8000_0004, 0x8000_0008, each 2 cycles apart.
- Response at 0x8000_0010 with bxx=1, prdt_taken=1, immb=0xFFFF_FFF0 -> next req_o_addr=0x8000_0000. Same with prdt_taken=0 -> 0x8000_0014.
- jal & rs1en, rs1_rdy=0 for 3 cycles, then rs1_val=0x8000_1003, immb=4 -> no request during the stall, then req_o_addr=0x8000_1004 (low bits masked).
- flush_i_valid with flush_i_pc=0x8000_2000 while in WAIT_RSP -> next response has ifu_o_drop=1, then req_o_addr=0x8000_2000. Flush in the same cycle as rsp_i_valid -> that response is dropped.
- fencei response -> no request until fencei_i_done, then req_o_addr = fencei PC+4. req_i_ready held low 5 cycles -> address stable throughout.
- Reset asserted in WAIT_RSP -> outputs return to reset values asynchronously; a late response has no effect on PC.

Source files
------------

// File: rtl/lieat_ifu_ifetch_req_pkg.sv
// Shared types and defaults for the IFU fetch-request block.
package lieat_ifu_ifetch_req_pkg;
    localparam int          LIEAT_XLEN     = 32;
    localparam int          LIEAT_BPU_IDX  = 6;
    localparam logic [31:0] LIEAT_RESET_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_REQ         = 2'd0,
        ST_WAIT_RSP    = 2'd1,
        ST_WAIT_JALR   = 2'd2,
        ST_WAIT_FENCEI = 2'd3
    } ifr_state_e;
endpackage

// File: rtl/lieat_ifu_nextpc.sv
// Combinational next-PC select: sequential, JAL, JALR or predicted-taken branch.
module lieat_ifu_nextpc
    import lieat_ifu_ifetch_req_pkg::*;
#(
    parameter int XLEN = LIEAT_XLEN
) (
    input  logic [XLEN-1:0] cur_pc_i,
    input  logic [XLEN-1:0] rsp_immb_i,
    input  logic [XLEN-1:0] jalr_imm_i,
    input  logic [XLEN-1:0] rs1_val_i,
    input  logic            jalr_wait_i,
    input  logic            jal_i,
    input  logic            rs1en_i,
    input  logic            bxx_i,
    input  logic            prdt_taken_i,
    output logic [XLEN-1:0] npc_o
);
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] rel_tgt;
    logic [XLEN-1:0] seq_pc;

    // While stalled on rs1 the response is gone, so use the latched immediate.
    assign jalr_sum = rs1_val_i + (jalr_wait_i ? jalr_imm_i : rsp_immb_i);
    assign rel_tgt  = cur_pc_i + rsp_immb_i;
    assign seq_pc   = cur_pc_i + XLEN'(4);

    always_comb begin
        npc_o = seq_pc;
        if (jalr_wait_i || (jal_i && rs1en_i))
            npc_o = {jalr_sum[XLEN-1:2], 2'b00};
        else if (jal_i || (bxx_i && prdt_taken_i))
            npc_o = rel_tgt;
    end
endmodule

// File: rtl/lieat_ifu_ifetch_req.sv
// IFU fetch-request side: owns the fetch PC, issues one request at a time,
// handles redirects, JALR operand stalls and FENCE.I drains.
module lieat_ifu_ifetch_req
    import lieat_ifu_ifetch_req_pkg::*;
#(
    parameter int              XLEN     = LIEAT_XLEN,
    parameter int              BPU_IDX  = LIEAT_BPU_IDX,
    parameter logic [XLEN-1:0] RESET_PC = LIEAT_RESET_PC
) (
    input  logic               clock,
    input  logic               reset,
    output logic               req_o_valid,
    input  logic               req_i_ready,
    output logic [XLEN-1:0]    req_o_addr,
    output logic [BPU_IDX-1:0] req_o_index,
    input  logic               rsp_i_valid,
    input  logic               rsp_i_jal,
    input  logic               rsp_i_rs1en,
    input  logic               rsp_i_bxx,
    input  logic [XLEN-1:0]    rsp_i_immb,
    input  logic               rsp_i_prdt_taken,
    input  logic               rsp_i_fencei,
    input  logic [XLEN-1:0]    jalr_i_rs1_val,
    input  logic               jalr_i_rs1_rdy,
    input  logic               flush_i_valid,
    input  logic [XLEN-1:0]    flush_i_pc,
    input  logic               fencei_i_done,
    output logic [XLEN-1:0]    ifu_o_pc,
    output logic               ifu_o_drop
);
    ifr_state_e      state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] ifu_pc_q;
    logic [XLEN-1:0] jalr_imm_q;
    logic            req_vld_q;
    logic            drop_q;
    logic [XLEN-1:0] npc_d;
    logic            jalr_stall;
    logic            is_fencei;

    lieat_ifu_nextpc #(.XLEN(XLEN)) u_nextpc (
        .cur_pc_i     (ifu_pc_q),
        .rsp_immb_i   (rsp_i_immb),
        .jalr_imm_i   (jalr_imm_q),
        .rs1_val_i    (jalr_i_rs1_val),
        .jalr_wait_i  (state_q == ST_WAIT_JALR),
        .jal_i        (rsp_i_jal),
        .rs1en_i      (rsp_i_rs1en),
        .bxx_i        (rsp_i_bxx),
        .prdt_taken_i (rsp_i_prdt_taken),
        .npc_o        (npc_d)
    );

    assign jalr_stall = rsp_i_jal && rsp_i_rs1en && !jalr_i_rs1_rdy;
    assign is_fencei  = rsp_i_fencei && !rsp_i_jal && !(rsp_i_bxx && rsp_i_prdt_taken);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_PC;
            ifu_pc_q   <= RESET_PC;
            jalr_imm_q <= '0;
            req_vld_q  <= 1'b1;
            drop_q     <= 1'b0;
        end else begin
            if (rsp_i_valid)
                drop_q <= 1'b0;
            if (flush_i_valid) begin
                pc_q <= flush_i_pc;
                // A request still in flight after this edge must have its response
                // discarded before a new one is issued (one outstanding at most).
                if (state_q == ST_WAIT_RSP && !rsp_i_valid) begin
                    drop_q    <= 1'b1;
                    state_q   <= ST_WAIT_RSP;
                    req_vld_q <= 1'b0;
                end else if (state_q == ST_REQ && req_i_ready) begin
                    drop_q    <= 1'b1;
                    ifu_pc_q  <= pc_q;
                    state_q   <= ST_WAIT_RSP;
                    req_vld_q <= 1'b0;
                end else begin
                    state_q   <= ST_REQ;
                    req_vld_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    ST_REQ: if (req_i_ready) begin
                        ifu_pc_q  <= pc_q;
                        state_q   <= ST_WAIT_RSP;
                        req_vld_q <= 1'b0;
                    end
                    ST_WAIT_RSP: if (rsp_i_valid) begin
                        if (drop_q) begin
                            state_q   <= ST_REQ;
                            req_vld_q <= 1'b1;
                        end else if (jalr_stall) begin
                            jalr_imm_q <= rsp_i_immb;
                            state_q    <= ST_WAIT_JALR;
                        end else begin
                            pc_q      <= npc_d;
                            state_q   <= is_fencei ? ST_WAIT_FENCEI : ST_REQ;
                            req_vld_q <= !is_fencei;
                        end
                    end
                    ST_WAIT_JALR: if (jalr_i_rs1_rdy) begin
                        pc_q      <= npc_d;
                        state_q   <= ST_REQ;
                        req_vld_q <= 1'b1;
                    end
                    ST_WAIT_FENCEI: if (fencei_i_done) begin
                        state_q   <= ST_REQ;
                        req_vld_q <= 1'b1;
                    end
                    default: begin
                        state_q   <= ST_REQ;
                        req_vld_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign req_o_valid = req_vld_q;
    assign req_o_addr  = pc_q;
    assign req_o_index = pc_q[BPU_IDX+1:2];
    assign ifu_o_pc    = ifu_pc_q;
    assign ifu_o_drop  = rsp_i_valid && (drop_q || flush_i_valid);
endmodule

// File: tb/tb_lieat_ifu_ifetch_req.sv
// Scoreboard bench: expected fetch addresses are queued as responses are driven
// and checked when the DUT presents its next request.
module tb_lieat_ifu_ifetch_req;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_o_valid, req_i_ready = 1'b0;
    logic [31:0] req_o_addr;
    logic [5:0]  req_o_index;
    logic        rsp_i_valid = 1'b0, rsp_i_jal = 1'b0, rsp_i_rs1en = 1'b0, rsp_i_bxx = 1'b0;
    logic [31:0] rsp_i_immb = '0;
    logic        rsp_i_prdt_taken = 1'b0, rsp_i_fencei = 1'b0;
    logic [31:0] jalr_i_rs1_val = '0;
    logic        jalr_i_rs1_rdy = 1'b0, flush_i_valid = 1'b0;
    logic [31:0] flush_i_pc = '0;
    logic        fencei_i_done = 1'b0;
    logic [31:0] ifu_o_pc;
    logic        ifu_o_drop;

    lieat_ifu_ifetch_req dut (
        .clock(clock), .reset(reset),
        .req_o_valid(req_o_valid), .req_i_ready(req_i_ready),
        .req_o_addr(req_o_addr), .req_o_index(req_o_index),
        .rsp_i_valid(rsp_i_valid), .rsp_i_jal(rsp_i_jal), .rsp_i_rs1en(rsp_i_rs1en),
        .rsp_i_bxx(rsp_i_bxx), .rsp_i_immb(rsp_i_immb),
        .rsp_i_prdt_taken(rsp_i_prdt_taken), .rsp_i_fencei(rsp_i_fencei),
        .jalr_i_rs1_val(jalr_i_rs1_val), .jalr_i_rs1_rdy(jalr_i_rs1_rdy),
        .flush_i_valid(flush_i_valid), .flush_i_pc(flush_i_pc),
        .fencei_i_done(fencei_i_done),
        .ifu_o_pc(ifu_o_pc), .ifu_o_drop(ifu_o_drop)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    int acc_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Wait for a request, compare it with the scoreboard head, accept it.
    task automatic issue(output logic [31:0] acc);
        int n = 0;
        logic [31:0] e;
        acc = '0;
        @(negedge clock);
        while (!req_o_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!req_o_valid) begin
            chk("req_timeout", 32'd0, 32'd1);
            return;
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hdead_beef;
        chk("req_addr", req_o_addr, e);
        chk("req_index", 32'(req_o_index), 32'(e[7:2]));
        acc = req_o_addr;
        req_i_ready = 1'b1;
        @(posedge clock);
        #1;
        acc_cyc = cyc;
        req_i_ready = 1'b0;
    endtask

    // Drive one response cycle; entered and left at posedge+1.
    task automatic respond(input logic jal, input logic rs1en, input logic rdy,
                           input logic [31:0] rs1v, input logic bxx, input logic tk,
                           input logic fi, input logic [31:0] immb,
                           input logic fl, input logic [31:0] flpc,
                           input logic exp_drop, input logic [31:0] exp_pc,
                           input logic push, input logic [31:0] nxt);
        rsp_i_valid = 1'b1; rsp_i_jal = jal; rsp_i_rs1en = rs1en; rsp_i_bxx = bxx;
        rsp_i_prdt_taken = tk; rsp_i_fencei = fi; rsp_i_immb = immb;
        jalr_i_rs1_rdy = rdy; jalr_i_rs1_val = rs1v;
        flush_i_valid = fl; flush_i_pc = flpc;
        @(negedge clock);
        chk("ifu_pc", ifu_o_pc, exp_pc);
        chk("drop", 32'(ifu_o_drop), 32'(exp_drop));
        if (push) exp_q.push_back(nxt);
        @(posedge clock);
        #1;
        rsp_i_valid = 1'b0; rsp_i_jal = 1'b0; rsp_i_rs1en = 1'b0; rsp_i_bxx = 1'b0;
        rsp_i_prdt_taken = 1'b0; rsp_i_fencei = 1'b0; rsp_i_immb = '0;
        jalr_i_rs1_rdy = 1'b0; flush_i_valid = 1'b0;
    endtask

    task automatic nop(input logic [31:0] pc);
        respond(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, pc, 1, pc + 32'd4);
    endtask

    initial begin
        logic [31:0] a;
        int prev;
        #12;
        chk("rst_valid", 32'(req_o_valid), 32'd1);
        chk("rst_addr", req_o_addr, 32'h8000_0000);
        chk("rst_index", 32'(req_o_index), 32'd0);
        chk("rst_ifu_pc", ifu_o_pc, 32'h8000_0000);
        chk("rst_drop", 32'(ifu_o_drop), 32'd0);
        #8 reset = 1'b1;
        exp_q.push_back(32'h8000_0000);

        // Sequential stream, one request every 2 cycles
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            issue(a);
            if (i > 0) chk("spacing", 32'(acc_cyc - prev), 32'd2);
            prev = acc_cyc;
            nop(a);
        end
        issue(a);
        respond(0, 0, 0, 0, 1, 1, 0, 32'hFFFF_FFF0, 0, 0, 0, a, 1, 32'h8000_0000);
        for (int i = 0; i < 4; i++) begin
            issue(a);
            nop(a);
        end
        issue(a);
        respond(0, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFF0, 0, 0, 0, a, 1, 32'h8000_0014);
        issue(a);
        respond(1, 0, 0, 0, 0, 0, 0, 32'h20, 0, 0, 0, a, 1, 32'h8000_0034);
        issue(a);
        respond(1, 1, 1, 32'h8000_3001, 0, 0, 0, 32'h2, 0, 0, 0, a, 1, 32'h8000_3000);

        // JALR with rs1 not ready for 3 cycles
        issue(a);
        respond(1, 1, 0, 0, 0, 0, 0, 32'h4, 0, 0, 0, a, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("jalr_stall_novalid", 32'(req_o_valid), 32'd0);
        end
        jalr_i_rs1_rdy = 1'b1; jalr_i_rs1_val = 32'h8000_1003;
        exp_q.push_back(32'h8000_1004);
        @(posedge clock);
        #1 jalr_i_rs1_rdy = 1'b0;

        // Flush while waiting for the response
        issue(a);
        flush_i_valid = 1'b1; flush_i_pc = 32'h8000_2000;
        @(posedge clock);
        #1 flush_i_valid = 1'b0;
        @(negedge clock);
        chk("flush_wait_novalid", 32'(req_o_valid), 32'd0);
        @(posedge clock);
        #1;
        respond(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, a, 1, 32'h8000_2000);

        // Flush in the same cycle as the response
        issue(a);
        respond(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_2100, 1, a, 1, 32'h8000_2100);

        // FENCE.I drain, then backpressure on the following request
        issue(a);
        respond(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, a, 1, 32'h8000_2104);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("fencei_novalid", 32'(req_o_valid), 32'd0);
        end
        fencei_i_done = 1'b1;
        @(posedge clock);
        #1 fencei_i_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("hold_valid", 32'(req_o_valid), 32'd1);
            chk("hold_addr", req_o_addr, 32'h8000_2104);
        end
        issue(a);
        nop(a);

        // Flush while idle in REQ, then wrap past the top of the address space
        flush_i_valid = 1'b1; flush_i_pc = 32'hFFFF_FFFC;
        void'(exp_q.pop_front());
        exp_q.push_back(32'hFFFF_FFFC);
        @(posedge clock);
        #1 flush_i_valid = 1'b0;
        issue(a);
        nop(a);
        exp_q.pop_front();
        exp_q.push_back(32'h0000_0000);
        issue(a);

        // Async reset while waiting for a response; late response is ignored
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", 32'(req_o_valid), 32'd1);
        chk("arst_addr", req_o_addr, 32'h8000_0000);
        chk("arst_ifu_pc", ifu_o_pc, 32'h8000_0000);
        chk("arst_drop", 32'(ifu_o_drop), 32'd0);
        exp_q.delete();
        exp_q.push_back(32'h8000_0000);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        rsp_i_valid = 1'b1; rsp_i_jal = 1'b1; rsp_i_immb = 32'h100;
        @(negedge clock);
        chk("late_drop", 32'(ifu_o_drop), 32'd0);
        @(posedge clock);
        #1;
        rsp_i_valid = 1'b0; rsp_i_jal = 1'b0; rsp_i_immb = '0;
        issue(a);
        nop(a);
        issue(a);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
